route_compute_scheduler: RTL
============================

// Module: route_compute_scheduler
// PURPOSE
//  Shares one route_compute datapath among all input ports of a VC router. Each port posts the
//  destination router id of its head flit. The block round-robin arbitrates the shared unit,
//  one computation per cycle, and holds a registered direction per port until the VC allocator acks it.
//  Sits between the input-buffer head-flit logic and VC allocation.
// PARAMETERS
//  NUM_PORTS       5   input ports (N,E,S,W,Local), indices 0..NUM_PORTS-1
//  NUM_ROUTERS     16  routers in the mesh
//  ROUTER_PER_ROW  4   mesh row width, passed to route_compute
//  ROUTER_ID_BITS  $clog2(NUM_ROUTERS)  derived; not overridden
// PORTS
//  clk             in   1                           clock, all state on posedge
//  reset           in   1                           asynchronous, active-high
//  current_router  in   ROUTER_ID_BITS              this router's id, static after reset
//  req             in   NUM_PORTS                   head flit present, per port
//  req_dest        in   NUM_PORTS*ROUTER_ID_BITS    destination id per port, sampled on accept
//  req_ready       out  NUM_PORTS                   port IDLE; req&req_ready = accept
//  route_valid     out  NUM_PORTS                   result held for port
//  route_dir       out  NUM_PORTS*2                 route_compute direction code per port
//  route_local     out  NUM_PORTS                   dest==current_router (eject); route_dir=0 then
//  route_ack       in   NUM_PORTS                   consume result; ignored unless route_valid
// BEHAVIOUR
//  - Per-port FSM {IDLE, WAIT, DONE}. req_ready = (state==IDLE); route_valid = (state==DONE).
//  - Cycle t, IDLE & req: capture req_dest into dest_q. If dest==current_router -> DONE at t+1,
//    route_local=1, route_dir=0, and no arbitration slot is used. Else -> WAIT at t+1.
//  - WAIT ports request the shared unit. One grant per cycle via round-robin. Granted port's
//    dest_q is muxed into the single route_compute instance, combinational. Its 2-bit output is
//    registered into the port's route_dir. Port -> DONE next cycle with route_local=0.
//  - Min latency, non-local: accept at t, grant at t+1, route_valid at t+2.
//  - Round-robin pointer is ptr, reset 0. Search starts at ptr, wraps NUM_PORTS-1 -> 0.
//    After a grant to port g, ptr = (g+1) mod NUM_PORTS. ptr holds when there is no grant.
//  - Any WAIT port is granted within NUM_PORTS cycles. No starvation.
//  - DONE & route_ack -> IDLE next cycle. req_ready rises that cycle, so back-to-back heads
//    cost at least one idle cycle.
//  - route_dir and route_local are stable throughout DONE. Do not change them until ack.
//  - req deasserted in WAIT: the port still completes. Cancel is not supported.
//  - route_ack outside DONE: no effect.
//  - All ports accept in the same cycle: each captures its own dest. Grants then serialize.
//  - Reset (async, any cycle, mid-operation): all FSMs go to IDLE and ptr=0.
//    route_valid=0, route_dir=0, route_local=0, req_ready=all-1 after reset.
//    dest_q is cleared to 0. In-flight work is discarded.
// STRUCTURE
//  - Shared package rc_pkg:
//    - port index enum (PORT_N,PORT_E,PORT_S,PORT_W,PORT_L)
//    - typedef dir_t = logic[1:0]
//    - per-port state enum rc_state_t {RC_IDLE,RC_WAIT,RC_DONE}
//  - Sub-module rc_rr_arbiter: NUM_PORTS req vector in, one-hot grant and grant_valid out.
//    It owns the ptr register.
//  - One existing route_compute instance, with NUM_ROUTERS and ROUTER_PER_ROW passed through.
//  - Per-port FSM and dest/dir registers live in a generate loop in this module.
// TESTING  (current_router=5; expected dir = route_compute reference model(5,dest))
//  1. Reset mid-WAIT.
//     - Stimulus: port1 accepted dest=15, assert reset the next cycle.
//     - Required: route_valid=0 and req_ready=5'b11111 immediately.
//     - After release, port1 is never granted stale data.
//  2. Single non-local request.
//     - Stimulus: port0 req, dest=12, at t; ack at t+4.
//     - Required: route_valid[0]=1 at t+2, dir=model(5,12), route_local=0.
//     - Result held through t+4. IDLE and req_ready[0]=1 at t+5.
//  3. Local eject.
//     - Stimulus: port4 req, dest=5.
//     - Required: route_valid[4]=1 at t+1, route_local=1, route_dir=0.
//     - No grant is consumed: a concurrent port2 dest=0 completes at t+2.
//  4. All five ports req at t, dests {0,3,10,12,15}, never acked.
//     - Required: route_valid asserts one per cycle, in order 0,1,2,3,4, at t+2..t+6.
//     - Each dir matches the model. ptr ends at 0.
//  5. Round-robin fairness.
//     - Stimulus: after ptr=3, ports 1 and 3 both WAIT.
//     - Required: port3 granted first, port1 next cycle. ptr ends at 2.
//  6. Ack and handshake edge cases.
//     - Stimulus: ack port2 while IDLE; ack and req in the same DONE cycle.
//     - Required: no state change in the first case.
//     - In the second, the ack is taken, the req is ignored, and the req is accepted the cycle after.

Source files
------------

// File: rtl/route_compute_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// rc_pkg
//   Shared types for the route-compute scheduler slice.
//   - port_idx_t : router input port index (N, E, S, W, Local)
//   - dir_t      : 2-bit output direction code produced by route_compute
//   - rc_state_t : per-port request state (IDLE, WAIT, DONE)
//   Direction codes line up with the port index of the output port they select,
//   so N=0, E=1, S=2, W=3. Ejection to Local is flagged separately by the
//   scheduler and carries direction code 0.
// -----------------------------------------------------------------------------
package rc_pkg;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_E = 3'd1,
        PORT_S = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_idx_t;

    typedef logic [1:0] dir_t;

    typedef enum logic [1:0] {
        RC_IDLE = 2'd0,
        RC_WAIT = 2'd1,
        RC_DONE = 2'd2
    } rc_state_t;

    localparam dir_t DIR_N = dir_t'(PORT_N);
    localparam dir_t DIR_E = dir_t'(PORT_E);
    localparam dir_t DIR_S = dir_t'(PORT_S);
    localparam dir_t DIR_W = dir_t'(PORT_W);

endpackage

// File: rtl/route_compute_scheduler_if.sv
// -----------------------------------------------------------------------------
// route_compute_scheduler_if
//   Bundles the head-flit request side and the route-result side of the
//   scheduler.
//   master (input-buffer / VC-allocator side):
//     drives  req, req_dest, route_ack
//     samples req_ready, route_valid, route_dir, route_local
//   slave  (scheduler side): the mirror image.
//   req_dest and route_dir are flattened per port, port p occupying
//   [p*ROUTER_ID_BITS +: ROUTER_ID_BITS] and [2*p +: 2] respectively.
// -----------------------------------------------------------------------------
interface route_compute_scheduler_if #(
    parameter int NUM_PORTS      = 5,
    parameter int ROUTER_ID_BITS = 4
) ();

    logic [NUM_PORTS-1:0]                req;
    logic [NUM_PORTS*ROUTER_ID_BITS-1:0] req_dest;
    logic [NUM_PORTS-1:0]                req_ready;
    logic [NUM_PORTS-1:0]                route_valid;
    logic [NUM_PORTS*2-1:0]              route_dir;
    logic [NUM_PORTS-1:0]                route_local;
    logic [NUM_PORTS-1:0]                route_ack;

    modport master (
        output req,
        output req_dest,
        output route_ack,
        input  req_ready,
        input  route_valid,
        input  route_dir,
        input  route_local
    );

    modport slave (
        input  req,
        input  req_dest,
        input  route_ack,
        output req_ready,
        output route_valid,
        output route_dir,
        output route_local
    );

endinterface

// File: rtl/route_compute.sv
// -----------------------------------------------------------------------------
// route_compute
//   Combinational dimension-ordered (XY) routing for a 2-D mesh.
//   Router id = y*ROUTER_PER_ROW + x, y grows towards South.
//   X is resolved first (E/W), then Y (S/N). Destination equal to the current
//   router yields DIR_N (0); the caller flags ejection on its own.
//   Ports:
//     i_current_router  this router's id
//     i_dest_router     destination router id
//     o_dir             output direction code (rc_pkg::dir_t)
// -----------------------------------------------------------------------------
module route_compute
    import rc_pkg::*;
#(
    parameter int NUM_ROUTERS    = 16,
    parameter int ROUTER_PER_ROW = 4
) (
    input  logic [$clog2(NUM_ROUTERS)-1:0] i_current_router,
    input  logic [$clog2(NUM_ROUTERS)-1:0] i_dest_router,
    output dir_t                           o_dir
);

    int w_cur_x;
    int w_cur_y;
    int w_dst_x;
    int w_dst_y;

    always_comb begin
        w_cur_x = int'(i_current_router) % ROUTER_PER_ROW;
        w_cur_y = int'(i_current_router) / ROUTER_PER_ROW;
        w_dst_x = int'(i_dest_router) % ROUTER_PER_ROW;
        w_dst_y = int'(i_dest_router) / ROUTER_PER_ROW;
        o_dir   = DIR_N;
        if (w_dst_x > w_cur_x) begin
            o_dir = DIR_E;
        end else if (w_dst_x < w_cur_x) begin
            o_dir = DIR_W;
        end else if (w_dst_y > w_cur_y) begin
            o_dir = DIR_S;
        end else begin
            o_dir = DIR_N;
        end
    end

endmodule

// File: rtl/route_compute_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rc_rr_arbiter
//   Round-robin arbiter for the shared route_compute unit.
//   The search starts at r_ptr and wraps NUM_PORTS-1 -> 0; after a grant to
//   port g the pointer moves to g+1 (mod NUM_PORTS), so the winner becomes the
//   lowest priority next cycle and every requester is served within
//   NUM_PORTS cycles. The pointer holds when nothing is granted.
//   Ports:
//     clk, reset      clock, asynchronous active-high reset (r_ptr -> 0)
//     i_req           per-port request vector
//     o_grant         one-hot grant (combinational)
//     o_grant_valid   any grant this cycle
// -----------------------------------------------------------------------------
module rc_rr_arbiter #(
    parameter int NUM_PORTS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] i_req,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic                 o_grant_valid
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W-1:0] w_gidx;
    logic [PTR_W-1:0] w_ptr_nxt;

    // Rotating priority search: first requester at or after r_ptr wins.
    always_comb begin
        o_grant       = '0;
        o_grant_valid = 1'b0;
        w_gidx        = '0;
        w_idx         = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_idx = PTR_W'((int'(r_ptr) + i) % NUM_PORTS);
            if (!o_grant_valid && i_req[w_idx]) begin
                o_grant_valid  = 1'b1;
                o_grant[w_idx] = 1'b1;
                w_gidx         = w_idx;
            end
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (o_grant_valid) begin
            if (w_gidx == PTR_W'(NUM_PORTS - 1)) begin
                w_ptr_nxt = '0;
            end else begin
                w_ptr_nxt = w_gidx + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/route_compute_scheduler.sv
// -----------------------------------------------------------------------------
// route_compute_scheduler
//   Shares one route_compute datapath among all input ports of a VC router.
//   Each port runs a small IDLE -> WAIT -> DONE FSM:
//     IDLE : req_ready=1. On req the destination is captured. A destination
//            equal to current_router ejects locally and goes straight to DONE
//            without using an arbitration slot; anything else goes to WAIT.
//     WAIT : competes for the shared route_compute unit. The granted port's
//            captured destination is steered into the single instance and
//            the resulting direction is registered in the same cycle.
//     DONE : route_valid=1, route_dir/route_local held stable until
//            route_ack, then back to IDLE (so back-to-back heads on one port
//            always see one IDLE cycle).
//   Ports:
//     clk             clock
//     reset           asynchronous, active-high; discards all in-flight work
//     current_router  this router's id, static after reset
//     bus             route_compute_scheduler_if.slave (req/req_dest/req_ready,
//                     route_valid/route_dir/route_local/route_ack)
// -----------------------------------------------------------------------------
module route_compute_scheduler
    import rc_pkg::*;
#(
    parameter int NUM_PORTS      = 5,
    parameter int NUM_ROUTERS    = 16,
    parameter int ROUTER_PER_ROW = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [$clog2(NUM_ROUTERS)-1:0] current_router,
    route_compute_scheduler_if.slave       bus
);

    localparam int ROUTER_ID_BITS = $clog2(NUM_ROUTERS);

    logic [NUM_PORTS-1:0]                w_wait;
    logic [NUM_PORTS-1:0]                w_grant;
    logic                                w_grant_valid;
    logic [NUM_PORTS*ROUTER_ID_BITS-1:0] w_dest_flat;
    logic [ROUTER_ID_BITS-1:0]           w_sel_dest;
    dir_t                                w_rc_dir;

    rc_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk           (clk),
        .reset         (reset),
        .i_req         (w_wait),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    // Grant is one-hot, so a plain select loop is a clean AND-OR mux.
    always_comb begin
        w_sel_dest = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant_valid && w_grant[i]) begin
                w_sel_dest = w_dest_flat[i*ROUTER_ID_BITS +: ROUTER_ID_BITS];
            end
        end
    end

    route_compute #(
        .NUM_ROUTERS    (NUM_ROUTERS),
        .ROUTER_PER_ROW (ROUTER_PER_ROW)
    ) u_route_compute (
        .i_current_router (current_router),
        .i_dest_router    (w_sel_dest),
        .o_dir            (w_rc_dir)
    );

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port

        rc_state_t                 r_state;
        rc_state_t                 w_state_nxt;
        logic [ROUTER_ID_BITS-1:0] r_dest;
        dir_t                      r_dir;
        logic                      r_local;
        logic [ROUTER_ID_BITS-1:0] w_req_dest;
        logic                      w_is_local;
        logic                      w_accept;
        logic                      w_take;

        assign w_req_dest = bus.req_dest[p*ROUTER_ID_BITS +: ROUTER_ID_BITS];
        assign w_is_local = (w_req_dest == current_router);
        assign w_accept   = (r_state == RC_IDLE) && bus.req[p];
        assign w_take     = (r_state == RC_WAIT) && w_grant[p];

        always_comb begin
            w_state_nxt = r_state;
            unique case (r_state)
                RC_IDLE: begin
                    if (bus.req[p]) begin
                        w_state_nxt = w_is_local ? RC_DONE : RC_WAIT;
                    end
                end
                RC_WAIT: begin
                    if (w_grant[p]) begin
                        w_state_nxt = RC_DONE;
                    end
                end
                RC_DONE: begin
                    // req is deliberately not looked at here: a new head is
                    // only accepted once the port is back in IDLE.
                    if (bus.route_ack[p]) begin
                        w_state_nxt = RC_IDLE;
                    end
                end
                default: w_state_nxt = RC_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= RC_IDLE;
                r_dest  <= '0;
                r_dir   <= '0;
                r_local <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                if (w_accept) begin
                    r_dest  <= w_req_dest;
                    r_dir   <= '0;
                    r_local <= w_is_local;
                end else if (w_take) begin
                    r_dir   <= w_rc_dir;
                    r_local <= 1'b0;
                end
            end
        end

        assign w_wait[p]                 = (r_state == RC_WAIT);
        assign w_dest_flat[p*ROUTER_ID_BITS +: ROUTER_ID_BITS] = r_dest;
        assign bus.req_ready[p]          = (r_state == RC_IDLE);
        assign bus.route_valid[p]        = (r_state == RC_DONE);
        assign bus.route_dir[2*p +: 2]   = r_dir;
        assign bus.route_local[p]        = r_local;
    end

endmodule
